// File: rtl/pcie_wr_commit_pkg.sv
// -----------------------------------------------------------------------------
// pcie_wr_commit_pkg
// Shared definitions for the local write-commit generator:
//   - TLP fmt_type codes for the power-user MWr32/MWr64 requests and the Cpl
//     that is returned as the commit.
//   - Bit offsets of the header fields used inside the 256-bit power-user
//     header (request and completion share the tag-high and PF/VF positions).
//   - t_commit_info: the per-write record carried through the commit FIFO.
//   - decode_req / build_cpl helpers used by the top level.
// -----------------------------------------------------------------------------
package pcie_wr_commit_pkg;

  localparam logic [7:0] FMT_MWR32 = 8'h40;
  localparam logic [7:0] FMT_MWR64 = 8'h60;
  localparam logic [7:0] FMT_CPL   = 8'h0A;

  localparam int HDR_W = 256;
  localparam int TAG_W = 10;
  localparam int PF_W  = 3;
  localparam int VF_W  = 11;

  // Power-user header field offsets within tdata[255:0].
  localparam int FMT_LSB     = 24;   // DW0 fmt_type [31:24]
  localparam int TAG9_BIT    = 23;   // DW0 10-bit tag, bit 9
  localparam int TAG8_BIT    = 19;   // DW0 10-bit tag, bit 8
  localparam int REQ_TAG_LSB = 40;   // request DW1 tag[7:0]
  localparam int CPL_TAG_LSB = 72;   // completion DW2 tag[7:0]
  localparam int PF_LSB      = 160;  // pf_num [162:160]
  localparam int VF_LSB      = 163;  // vf_num [173:163]
  localparam int VFA_BIT     = 174;  // vf_active

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PF_W-1:0]  pf_num;
    logic [VF_W-1:0]  vf_num;
    logic             vf_active;
  } t_commit_info;

  function automatic logic is_mwr(input logic [7:0] fmt_type);
    return (fmt_type == FMT_MWR32) || (fmt_type == FMT_MWR64);
  endfunction

  // Pull the fields a commit must echo out of a request header.
  function automatic t_commit_info decode_req(input logic [HDR_W-1:0] hdr);
    t_commit_info info;
    info.tag       = {hdr[TAG9_BIT], hdr[TAG8_BIT], hdr[REQ_TAG_LSB +: 8]};
    info.pf_num    = hdr[PF_LSB +: PF_W];
    info.vf_num    = hdr[VF_LSB +: VF_W];
    info.vf_active = hdr[VFA_BIT];
    return info;
  endfunction

  // Data-less completion header: length, status and byte count stay zero.
  function automatic logic [HDR_W-1:0] build_cpl(input t_commit_info info);
    logic [HDR_W-1:0] hdr;
    hdr                      = '0;
    hdr[FMT_LSB +: 8]        = FMT_CPL;
    hdr[TAG9_BIT]            = info.tag[9];
    hdr[TAG8_BIT]            = info.tag[8];
    hdr[CPL_TAG_LSB +: 8]    = info.tag[7:0];
    hdr[PF_LSB +: PF_W]      = info.pf_num;
    hdr[VF_LSB +: VF_W]      = info.vf_num;
    hdr[VFA_BIT]             = info.vf_active;
    return hdr;
  endfunction

endpackage

// File: rtl/pcie_wr_commit_fifo.sv
// -----------------------------------------------------------------------------
// pcie_wr_commit_fifo
// Synchronous show-ahead FIFO of t_commit_info records.
//   clk, rst   : clock, asynchronous active-high reset (flushes contents)
//   i_push     : write i_data (ignored when full)
//   i_data     : record to store
//   i_pop      : consume the head entry (ignored when empty)
//   o_data     : head entry, valid whenever o_empty is low
//   o_full     : DEPTH entries stored
//   o_empty    : no entries stored
// Status flags and pointers are registered, so a pushed entry becomes
// visible the cycle after the push.
// -----------------------------------------------------------------------------
module pcie_wr_commit_fifo
  import pcie_wr_commit_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  t_commit_info i_data,
  input  logic         i_pop,
  output t_commit_info o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  t_commit_info  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pcie_wr_commit_gen.sv
// -----------------------------------------------------------------------------
// pcie_wr_commit_gen
// Forwards the AFU TX A stream to the FIM unchanged and, for every
// power-user memory write that completes, returns an in-order data-less Cpl
// (the local write commit) on the RX B stream.
//   clk, rst                     : clock, asynchronous active-high reset
//   afu_tx_*                     : TX A from the AFU (tready combinational)
//   fim_tx_*                     : TX A toward the FIM, zero latency
//   rxb_*                        : single-beat commit completions to the AFU
//   cmt_outstanding              : reserved plus queued commits (0..CMT_DEPTH)
//
// Handshake: every stream moves a beat on a cycle where tvalid and tready are
// both high; a source holds tvalid and payload stable until that happens, and
// tvalid never depends on tready of the same interface.
//
// A commit slot is reserved when a write SOP is accepted, so a write is only
// admitted when its commit is guaranteed room. Only SOP beats can stall;
// the remainder of a packet always flows.
// -----------------------------------------------------------------------------
module pcie_wr_commit_gen
  import pcie_wr_commit_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int USER_W    = 10,
  parameter int CMT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  // TX A from the AFU
  input  logic                         afu_tx_tvalid,
  output logic                         afu_tx_tready,
  input  logic [DATA_W-1:0]            afu_tx_tdata,
  input  logic [DATA_W/8-1:0]          afu_tx_tkeep,
  input  logic                         afu_tx_tlast,
  input  logic [USER_W-1:0]            afu_tx_tuser,
  // TX A toward the FIM
  output logic                         fim_tx_tvalid,
  input  logic                         fim_tx_tready,
  output logic [DATA_W-1:0]            fim_tx_tdata,
  output logic [DATA_W/8-1:0]          fim_tx_tkeep,
  output logic                         fim_tx_tlast,
  output logic [USER_W-1:0]            fim_tx_tuser,
  // RX B commit stream
  output logic                         rxb_tvalid,
  input  logic                         rxb_tready,
  output logic [DATA_W-1:0]            rxb_tdata,
  output logic [DATA_W/8-1:0]          rxb_tkeep,
  output logic                         rxb_tlast,
  output logic [USER_W-1:0]            rxb_tuser,
  output logic [$clog2(CMT_DEPTH):0]   cmt_outstanding
);

  localparam int CW = $clog2(CMT_DEPTH) + 1;

  logic          r_sop;       // next accepted beat starts a packet
  logic          r_in_wr;     // current multi-beat packet is a tracked write
  logic [CW-1:0] r_cnt;       // reserved + queued commits
  t_commit_info  r_info;      // fields latched from the write's SOP

  logic          w_is_write;
  logic          w_wr_sop;
  logic          w_stall;
  logic          w_fire;
  logic          w_reserve;
  logic          w_push;
  logic          w_pop;
  t_commit_info  w_beat_info;
  t_commit_info  w_push_info;
  t_commit_info  w_fifo_data;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  // Power-user mode is tuser[0]==0; DM-mode traffic is never committed here.
  assign w_is_write  = ~afu_tx_tuser[0] & is_mwr(afu_tx_tdata[FMT_LSB +: 8]);
  assign w_wr_sop    = r_sop & w_is_write;
  assign w_stall     = w_wr_sop & (r_cnt == CW'(CMT_DEPTH));
  assign w_beat_info = decode_req(afu_tx_tdata[HDR_W-1:0]);

  // Zero-latency forwarding.
  assign fim_tx_tvalid = afu_tx_tvalid & ~w_stall;
  assign afu_tx_tready = fim_tx_tready & ~w_stall;
  assign fim_tx_tdata  = afu_tx_tdata;
  assign fim_tx_tkeep  = afu_tx_tkeep;
  assign fim_tx_tlast  = afu_tx_tlast;
  assign fim_tx_tuser  = afu_tx_tuser;

  assign w_fire    = afu_tx_tvalid & afu_tx_tready;
  assign w_reserve = w_fire & w_wr_sop;
  // Single-beat writes push straight from the current beat; multi-beat
  // writes push the fields latched at their SOP.
  assign w_push      = w_fire & afu_tx_tlast & (r_sop ? w_is_write : r_in_wr);
  assign w_push_info = r_sop ? w_beat_info : r_info;
  assign w_pop       = rxb_tvalid & rxb_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sop   <= 1'b1;
      r_in_wr <= 1'b0;
      r_cnt   <= '0;
      r_info  <= '0;
    end else begin
      if (w_reserve && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_reserve && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (w_fire) begin
        r_sop <= afu_tx_tlast;
        if (r_sop) begin
          r_in_wr <= w_is_write & ~afu_tx_tlast;
        end else if (afu_tx_tlast) begin
          r_in_wr <= 1'b0;
        end
      end

      if (w_reserve) begin
        r_info <= w_beat_info;
      end
    end
  end

  // The reservation count bounds occupancy, so the full guard never bites
  // in normal operation; it only keeps the FIFO self-consistent.
  pcie_wr_commit_fifo #(
    .DEPTH (CMT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push & ~w_fifo_full),
    .i_data  (w_push_info),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Commit beat; payload is forced to zero whenever no commit is presented
  // so stale FIFO storage never reaches the outputs.
  always_comb begin
    rxb_tdata = '0;
    rxb_tkeep = '0;
    if (!w_fifo_empty) begin
      rxb_tdata[HDR_W-1:0]   = build_cpl(w_fifo_data);
      rxb_tkeep[HDR_W/8-1:0] = '1;
    end
  end

  assign rxb_tvalid      = ~w_fifo_empty;
  assign rxb_tlast       = ~w_fifo_empty;
  assign rxb_tuser       = '0;
  assign cmt_outstanding = r_cnt;

endmodule

// File: tb/tb_pcie_wr_commit_gen.sv
// -----------------------------------------------------------------------------
// tb_pcie_wr_commit_gen
// Self-checking bench: forwarded beats and expected commit headers are queued
// as stimulus is driven and compared as the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_pcie_wr_commit_gen;

  localparam int DATA_W    = 512;
  localparam int USER_W    = 10;
  localparam int CMT_DEPTH = 16;
  localparam int CW        = $clog2(CMT_DEPTH) + 1;

  typedef struct {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic                last;
    logic [USER_W-1:0]   user;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 afu_tx_tvalid;
  logic                 afu_tx_tready;
  logic [DATA_W-1:0]    afu_tx_tdata;
  logic [DATA_W/8-1:0]  afu_tx_tkeep;
  logic                 afu_tx_tlast;
  logic [USER_W-1:0]    afu_tx_tuser;
  logic                 fim_tx_tvalid;
  logic                 fim_tx_tready;
  logic [DATA_W-1:0]    fim_tx_tdata;
  logic [DATA_W/8-1:0]  fim_tx_tkeep;
  logic                 fim_tx_tlast;
  logic [USER_W-1:0]    fim_tx_tuser;
  logic                 rxb_tvalid;
  logic                 rxb_tready;
  logic [DATA_W-1:0]    rxb_tdata;
  logic [DATA_W/8-1:0]  rxb_tkeep;
  logic                 rxb_tlast;
  logic [USER_W-1:0]    rxb_tuser;
  logic [CW-1:0]        cmt_outstanding;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_pops   = 0;
  logic tog_en = 1'b0;

  logic [255:0] exp_q[$];
  beat_t        fwd_q[$];
  int           pop_cyc_q[$];

  logic              r_hold;
  logic [DATA_W-1:0] r_hold_data;

  pcie_wr_commit_gen #(
    .DATA_W    (DATA_W),
    .USER_W    (USER_W),
    .CMT_DEPTH (CMT_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .afu_tx_tvalid   (afu_tx_tvalid),
    .afu_tx_tready   (afu_tx_tready),
    .afu_tx_tdata    (afu_tx_tdata),
    .afu_tx_tkeep    (afu_tx_tkeep),
    .afu_tx_tlast    (afu_tx_tlast),
    .afu_tx_tuser    (afu_tx_tuser),
    .fim_tx_tvalid   (fim_tx_tvalid),
    .fim_tx_tready   (fim_tx_tready),
    .fim_tx_tdata    (fim_tx_tdata),
    .fim_tx_tkeep    (fim_tx_tkeep),
    .fim_tx_tlast    (fim_tx_tlast),
    .fim_tx_tuser    (fim_tx_tuser),
    .rxb_tvalid      (rxb_tvalid),
    .rxb_tready      (rxb_tready),
    .rxb_tdata       (rxb_tdata),
    .rxb_tkeep       (rxb_tkeep),
    .rxb_tlast       (rxb_tlast),
    .rxb_tuser       (rxb_tuser),
    .cmt_outstanding (cmt_outstanding)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) fim_tx_tready = ~fim_tx_tready;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] mk_req(input logic [7:0] fmt, input logic [9:0] tag,
                                               input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
    logic [DATA_W-1:0] d;
    d          = rand_data();
    d[31:24]   = fmt;
    d[23]      = tag[9];
    d[19]      = tag[8];
    d[47:40]   = tag[7:0];
    d[162:160] = pf;
    d[173:163] = vf;
    d[174]     = vfa;
    return d;
  endfunction

  function automatic logic [255:0] mk_cpl(input logic [9:0] tag, input logic [2:0] pf,
                                          input logic [10:0] vf, input logic vfa);
    logic [255:0] c;
    c          = '0;
    c[31:24]   = 8'h0A;
    c[23]      = tag[9];
    c[19]      = tag[8];
    c[79:72]   = tag[7:0];
    c[162:160] = pf;
    c[173:163] = vf;
    c[174]     = vfa;
    return c;
  endfunction

  task automatic drive_idle();
    afu_tx_tvalid = 1'b0;
    afu_tx_tdata  = '0;
    afu_tx_tkeep  = '0;
    afu_tx_tlast  = 1'b0;
    afu_tx_tuser  = '0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, input logic [USER_W-1:0] u);
    beat_t b;
    logic  acc;
    acc           = 1'b0;
    afu_tx_tdata  = d;
    afu_tx_tkeep  = {$urandom, $urandom};
    afu_tx_tlast  = last;
    afu_tx_tuser  = u;
    afu_tx_tvalid = 1'b1;
    b.data = d; b.keep = afu_tx_tkeep; b.last = last; b.user = u;
    fwd_q.push_back(b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (afu_tx_tready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", DATA_W'(acc), DATA_W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] fmt, input logic [9:0] tag, input logic [2:0] pf,
                          input logic [10:0] vf, input logic vfa, input logic dm, input int nb);
    logic [DATA_W-1:0] d;
    logic [USER_W-1:0] u;
    d    = mk_req(fmt, tag, pf, vf, vfa);
    u    = USER_W'($urandom);
    u[0] = dm;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        d = rand_data();
        u = USER_W'($urandom);
      end
      send_beat(d, (i == nb - 1), u);
    end
    if (!dm && (fmt == 8'h40 || fmt == 8'h60)) exp_q.push_back(mk_cpl(tag, pf, vf, vfa));
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk(tag, DATA_W'(exp_q.size()), DATA_W'(0));
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && fim_tx_tvalid && fim_tx_tready) begin
      if (fwd_q.size() == 0) begin
        chk("fwd_unexpected", DATA_W'(1), DATA_W'(0));
      end else begin
        beat_t b;
        b = fwd_q.pop_front();
        chk("fwd_data", fim_tx_tdata, b.data);
        chk("fwd_ctl", DATA_W'({fim_tx_tkeep, fim_tx_tlast, fim_tx_tuser}),
                       DATA_W'({b.keep, b.last, b.user}));
      end
    end
    if (!rst && afu_tx_tvalid) begin
      chk("fwd_ready_match", DATA_W'(afu_tx_tready & afu_tx_tvalid),
                             DATA_W'(fim_tx_tready & fim_tx_tvalid));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      r_hold = 1'b0;
    end else begin
      if (r_hold && rxb_tvalid) chk("cpl_hold_stable", rxb_tdata, r_hold_data);
      if (rxb_tvalid && rxb_tready) begin
        n_pops++;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("spurious_commit", DATA_W'(1), DATA_W'(0));
        end else begin
          logic [255:0]        e;
          logic [DATA_W/8-1:0] k;
          e = exp_q.pop_front();
          k = '0;
          k[31:0] = '1;
          chk("cpl_hdr", DATA_W'(rxb_tdata[255:0]), DATA_W'(e));
          chk("cpl_upper", DATA_W'(rxb_tdata[DATA_W-1:256]), DATA_W'(0));
          chk("cpl_keep", DATA_W'(rxb_tkeep), DATA_W'(k));
          chk("cpl_last_user", DATA_W'({rxb_tlast, rxb_tuser}), DATA_W'({1'b1, {USER_W{1'b0}}}));
        end
      end
      r_hold      = rxb_tvalid && !rxb_tready;
      r_hold_data = rxb_tdata;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int pops0;
    rst           = 1'b1;
    fim_tx_tready = 1'b0;
    rxb_tready    = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rxb_tvalid", DATA_W'(rxb_tvalid), DATA_W'(0));
    chk("rst_rxb_tdata", rxb_tdata, '0);
    chk("rst_rxb_ctl", DATA_W'({rxb_tkeep, rxb_tlast, rxb_tuser}), DATA_W'(0));
    chk("rst_outstanding", DATA_W'(cmt_outstanding), DATA_W'(0));
    chk("rst_fim_tvalid", DATA_W'(fim_tx_tvalid), DATA_W'(0));
    rst           = 1'b0;
    fim_tx_tready = 1'b1;
    rxb_tready    = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_afu_tready", DATA_W'(afu_tx_tready), DATA_W'(1));

    // 1: single-beat MWr64
    send_pkt(8'h60, 10'h02A, 3'd0, 11'd3, 1'b1, 1'b0, 1);
    drive_idle();
    chk("t1_valid_after_last", DATA_W'(rxb_tvalid), DATA_W'(1));
    chk("t1_outstanding_1", DATA_W'(cmt_outstanding), DATA_W'(1));
    @(posedge clk);
    #1;
    chk("t1_outstanding_0", DATA_W'(cmt_outstanding), DATA_W'(0));
    chk("t1_valid_clear", DATA_W'(rxb_tvalid), DATA_W'(0));

    // 2: 3-beat MWr32 with FIM backpressure toggling every cycle
    tog_en = 1'b1;
    send_pkt(8'h40, 10'd5, 3'd2, 11'd17, 1'b0, 1'b0, 3);
    drive_idle();
    tog_en        = 1'b0;
    fim_tx_tready = 1'b1;
    wait_drain("t2_drain", 50);
    chk("t2_fwd_all", DATA_W'(fwd_q.size()), DATA_W'(0));

    // 3: MRd64, DM-mode write and a 2-beat completion: no commits
    pops0 = n_pops;
    send_pkt(8'h20, 10'd7, 3'd1, 11'd0, 1'b0, 1'b0, 1);
    send_pkt(8'h60, 10'd8, 3'd1, 11'd2, 1'b1, 1'b1, 2);
    send_pkt(8'h4A, 10'd9, 3'd0, 11'd0, 1'b0, 1'b0, 2);
    drive_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("t3_no_commit", DATA_W'(n_pops - pops0), DATA_W'(0));
    chk("t3_outstanding", DATA_W'(cmt_outstanding), DATA_W'(0));

    // 4: fill all commit slots, 17th write stalls until one pop
    rxb_tready = 1'b0;
    for (int t = 0; t < 16; t++)
      send_pkt(8'h60, 10'(t), 3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 1'b0, 1);
    chk("t4_outstanding_full", DATA_W'(cmt_outstanding), DATA_W'(16));
    fork
      send_pkt(8'h40, 10'd16, 3'd5, 11'd100, 1'b1, 1'b0, 1);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t4_stall_ready", DATA_W'(afu_tx_tready), DATA_W'(0));
        chk("t4_stall_fim_valid", DATA_W'(fim_tx_tvalid), DATA_W'(0));
        chk("t4_stall_count", DATA_W'(cmt_outstanding), DATA_W'(16));
        rxb_tready = 1'b1;
        @(posedge clk);
        #1;
        rxb_tready = 1'b0;
      end
    join
    drive_idle();
    chk("t4_outstanding_after", DATA_W'(cmt_outstanding), DATA_W'(16));
    rxb_tready = 1'b1;
    wait_drain("t4_drain", 100);
    chk("t4_outstanding_0", DATA_W'(cmt_outstanding), DATA_W'(0));

    // 5: back-to-back writes, one commit per cycle
    pop_cyc_q.delete();
    for (int t = 0; t < 8; t++)
      send_pkt(8'h60, 10'h100 + 10'(t), 3'd7, 11'(t * 9), 1'b1, 1'b0, 1);
    drive_idle();
    wait_drain("t5_drain", 50);
    chk("t5_pop_count", DATA_W'(pop_cyc_q.size()), DATA_W'(8));
    if (pop_cyc_q.size() == 8)
      chk("t5_consecutive", DATA_W'(pop_cyc_q[7] - pop_cyc_q[0]), DATA_W'(7));

    // 6: reset mid-packet with commits queued
    rxb_tready = 1'b0;
    for (int t = 0; t < 3; t++) send_pkt(8'h40, 10'(20 + t), 3'd1, 11'd1, 1'b0, 1'b0, 1);
    send_beat(mk_req(8'h60, 10'h033, 3'd2, 11'd4, 1'b1), 1'b0, '0);
    afu_tx_tdata = rand_data();
    afu_tx_tlast = 1'b0;
    #2;
    rst = 1'b1;
    drive_idle();
    exp_q.delete();
    fwd_q.delete();
    @(posedge clk);
    #1;
    chk("t6_rst_valid", DATA_W'(rxb_tvalid), DATA_W'(0));
    chk("t6_rst_tdata", rxb_tdata, '0);
    chk("t6_rst_ctl", DATA_W'({rxb_tkeep, rxb_tlast}), DATA_W'(0));
    chk("t6_rst_outstanding", DATA_W'(cmt_outstanding), DATA_W'(0));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_spurious", DATA_W'(rxb_tvalid), DATA_W'(0));
    pops0      = n_pops;
    rxb_tready = 1'b1;
    send_pkt(8'h60, 10'd9, 3'd3, 11'd6, 1'b0, 1'b0, 2);
    drive_idle();
    wait_drain("t6_drain", 50);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_one_commit", DATA_W'(n_pops - pops0), DATA_W'(1));
    chk("t6_outstanding_0", DATA_W'(cmt_outstanding), DATA_W'(0));

    chk("end_exp_empty", DATA_W'(exp_q.size()), DATA_W'(0));
    chk("end_fwd_empty", DATA_W'(fwd_q.size()), DATA_W'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcie_wr_commit_gen.md
Name: pcie_wr_commit_gen

Overview:
- FIM-side generator for the local write-commit stream that AFUs receive on their RX B port.
- Sits between an AFU TX A stream and the downstream PF/VF mux path. Forwards TX A unchanged.
- For every power-user memory write that completes on TX A, returns a data-less Cpl carrying the write's tag and PF/VF on RX B.
- Commits come back in the same order as the writes.

Parameters:
- DATA_W, 512, TX A / RX B tdata width; must be at least 256.
- USER_W, 10, tuser_vendor width.
- CMT_DEPTH, 16, commit FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- afu_tx_tvalid / afu_tx_tready  in / out  1 / 1  TX A from the AFU.
- afu_tx_tdata / afu_tx_tkeep / afu_tx_tlast / afu_tx_tuser  in  DATA_W / DATA_W/8 / 1 / USER_W  TX A payload from the AFU.
- fim_tx_tvalid / fim_tx_tready  out / in  1 / 1  TX A toward the FIM.
- fim_tx_tdata / fim_tx_tkeep / fim_tx_tlast / fim_tx_tuser  out  same widths  forwarded TX A payload.
- rxb_tvalid / rxb_tready  out / in  1 / 1  RX B commit stream to the AFU.
- rxb_tdata / rxb_tkeep / rxb_tlast / rxb_tuser  out  DATA_W / DATA_W/8 / 1 / USER_W  commit Cpl beat.
- cmt_outstanding  out  $clog2(CMT_DEPTH)+1  reserved plus queued commits.

Behaviour:
- Reset values: all outputs 0, except afu_tx_tready, which is combinational. FIFO empty. SOP flag = 1.
- Forwarding is combinational, zero latency.
  - fim_tx_* = afu_tx_*.
  - fim_tx_tvalid = afu_tx_tvalid & ~stall.
  - afu_tx_tready = fim_tx_tready & ~stall.
- SOP flag: set on reset and after each accepted beat with tlast=1; cleared after an accepted beat with tlast=0.
- Write detection on an SOP beat:
  - afu_tx_tuser[0]=0 (power-user mode), and
  - tdata[31:24] (fmt_type) is 8'h40 (MWr32) or 8'h60 (MWr64).
  - All other TLPs (reads, DM-mode, completions, messages) pass through and generate no commit.
- Reservation:
  - stall = SOP & is_write & (cmt_outstanding == CMT_DEPTH).
  - On an accepted write SOP, cmt_outstanding increments and the header fields are latched: tag (10 bits), pf_num, vf_num, vf_active.
  - Stall applies only at SOP. Once started, a packet never stalls on FIFO space.
- Push: when the tlast beat of a detected write is accepted, the latched fields are pushed to the FIFO.
  - Single-beat write (SOP and tlast together): the fields come straight from the current beat.
- FIFO: registered. A pushed entry is visible on rxb_tvalid no earlier than the cycle after the push.
- Commit beat:
  - Always single beat: tlast=1, tkeep lower 32 bytes all 1, upper bytes 0, tuser=0.
  - Header in tdata[255:0], PU Cpl layout: fmt_type 8'h0A, length 0, cpl_status 0, byte_count 0, tag copied, pf/vf/vf_active copied.
  - All other bits 0.
- Pop: on rxb_tvalid & rxb_tready; cmt_outstanding decrements.
- Same-cycle reserve and pop: cmt_outstanding is unchanged.
- Pop with rxb_tready held high: one commit per cycle. rxb_tdata stays stable while tvalid=1 and tready=0.
- Reset asserted mid-packet or with entries queued:
  - FIFO flushed, counters cleared, SOP flag set.
  - A partially forwarded write produces no commit.
  - No spurious commit after reset is released.
- cmt_outstanding never exceeds CMT_DEPTH and never underflows.

Decomposition:
- Shared package pcie_wr_commit_pkg:
  - FMT_MWR32 = 8'h40, FMT_MWR64 = 8'h60, FMT_CPL = 8'h0A.
  - Struct t_commit_info {tag[9:0], pf_num, vf_num, vf_active}.
  - Header field offsets reuse pcie_ss_hdr_pkg PU request/Cpl header types.
- One sub-module: pcie_wr_commit_fifo, a synchronous show-ahead FIFO of t_commit_info (CMT_DEPTH entries, registered output, full/empty flags).
- Reservation counter and header build stay in the top.

Test Plan:
- Single-beat MWr64, tag 10'h02A, pf 0, vf 3, vf_active 1, rxb_tready=1 -> one rxb beat one cycle after tlast; fmt 8'h0A, tag 10'h02A, vf 3; cmt_outstanding returns to 0.
- 3-beat MWr32 tag 5 with fim_tx_tready toggling every cycle -> all 3 beats forwarded bit-exact; exactly one commit, tag 5, only after the third beat is accepted.
- MRd64 tag 7, then a DM-mode write (tuser[0]=1) -> both forwarded; rxb_tvalid stays 0.
- rxb_tready=0, issue 17 single-beat writes with tags 0..16 -> first 16 accepted, cmt_outstanding=16; afu_tx_tready=0 at the 17th SOP; raising rxb_tready for one cycle pops tag 0 and the 17th write is then accepted. Commits drain in order 0..16.
- Back-to-back writes, tags 0x100..0x107, rxb_tready=1 -> 8 commits on consecutive cycles in tag order; no drops.
- Assert rst during beat 2 of a 4-beat write with 3 commits queued -> all outputs 0 next cycle and FIFO empty; after release a fresh write tag 9 yields exactly one commit, tag 9.
